// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller (load-use, branch, multi-cycle, dmem freeze); optional perf counters via HAZARD_PERF_EN
module hazard_ctrl #(
   parameter int MC_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_uses_rs1,
   input  logic        id_uses_rs2,
   input  logic [4:0]  ex_rd,
   input  logic        ex_mem_read,
   input  logic        ex_mc_start,
   input  logic        mc_done,
   input  logic        ex_branch_taken,
   input  logic        mem_req,
   input  logic        dmem_ready,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        idex_en,
   output logic        exmem_en,
   output logic        memwb_en,
   output logic        ifid_flush,
   output logic        idex_bubble,
   output logic        exmem_bubble,
   output logic        mc_ack,
   output logic        mc_busy,
   output logic        mc_err,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_flush_cnt
);

   localparam int CW = $clog2(MC_TIMEOUT + 1);

   typedef enum logic [0:0] {
      RUN     = 1'b0,
      MC_WAIT = 1'b1
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] tmo_cnt;
   logic [CW-1:0] tmo_cnt_nxt;
   logic          err_set;
   logic          freeze;
   logic          load_use;
   logic          tmo_hit;

   // A pending data-memory access freezes the whole pipe, including this FSM.
   assign freeze = mem_req & ~dmem_ready;

   // Load in EX whose destination is read by the instruction in ID; x0 never hazards.
   assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                     ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                      (id_uses_rs2 && (id_rs2 == ex_rd)));

   // The counter holds 1 in the first wait cycle, so it equals MC_TIMEOUT in the last one.
   assign tmo_hit = (tmo_cnt == CW'(MC_TIMEOUT));

   assign mc_busy = (state == MC_WAIT);

   // Prioritised stall/flush decode; outputs react in the same cycle as the inputs.
   always_comb begin
      state_nxt    = state;
      tmo_cnt_nxt  = tmo_cnt;
      err_set      = 1'b0;
      pc_en        = 1'b1;
      ifid_en      = 1'b1;
      idex_en      = 1'b1;
      exmem_en     = 1'b1;
      memwb_en     = 1'b1;
      ifid_flush   = 1'b0;
      idex_bubble  = 1'b0;
      exmem_bubble = 1'b0;
      mc_ack       = 1'b0;
      if (!rst_n) begin
         // While in reset nothing advances and every register is loaded with a NOP.
         pc_en        = 1'b0;
         ifid_en      = 1'b0;
         idex_en      = 1'b0;
         exmem_en     = 1'b0;
         memwb_en     = 1'b0;
         ifid_flush   = 1'b1;
         idex_bubble  = 1'b1;
         exmem_bubble = 1'b1;
      end else if (freeze) begin
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         idex_en  = 1'b0;
         exmem_en = 1'b0;
         memwb_en = 1'b0;
      end else if ((state == MC_WAIT) && (mc_done || tmo_hit)) begin
         // Release: the op result (or the abort) moves on with the pipe this cycle.
         mc_ack      = mc_done;
         state_nxt   = RUN;
         tmo_cnt_nxt = '0;
         err_set     = ~mc_done;
      end else if (state == MC_WAIT) begin
         pc_en        = 1'b0;
         ifid_en      = 1'b0;
         idex_en      = 1'b0;
         exmem_bubble = 1'b1;
         tmo_cnt_nxt  = tmo_cnt + CW'(1);
      end else if (ex_mc_start) begin
         // mc_done is deliberately ignored here; the op has only just started.
         pc_en        = 1'b0;
         ifid_en      = 1'b0;
         idex_en      = 1'b0;
         exmem_bubble = 1'b1;
         state_nxt    = MC_WAIT;
         tmo_cnt_nxt  = CW'(1);
      end else if (ex_branch_taken) begin
         // Branch wins over load-use: the ID instruction is on the wrong path anyway.
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (load_use) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_bubble = 1'b1;
      end
   end

   // FSM state, timeout counter and sticky error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= RUN;
         tmo_cnt <= '0;
         mc_err  <= 1'b0;
      end else begin
         state   <= state_nxt;
         tmo_cnt <= tmo_cnt_nxt;
         if (err_set) begin
            mc_err <= 1'b1;
         end
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_q;
   logic [31:0] flush_q;

   // Free-running event counters; they wrap naturally at 2^32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (!pc_en) begin
            stall_q <= stall_q + 32'd1;
         end
         if (ifid_flush) begin
            flush_q <= flush_q + 32'd1;
         end
      end
   end

   assign perf_stall_cnt = stall_q;
   assign perf_flush_cnt = flush_q;
`else
   assign perf_stall_cnt = '0;
   assign perf_flush_cnt = '0;
`endif

endmodule
